// File: rtl/dp_ram_bypass_pipe_if.sv
// dp_ram_bypass_pipe_if: read/write port bundle of the bypassing 1R/1W RAM
interface dp_ram_bypass_pipe_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  init_busy;
    logic                  CEA;
    logic [ADDR_WIDTH-1:0] AA;
    logic [DATA_WIDTH-1:0] QA;
    logic                  QA_valid;
    logic                  CEB;
    logic [ADDR_WIDTH-1:0] AB;
    logic [DATA_WIDTH-1:0] DB;
    logic [DATA_WIDTH-1:0] BWB;
    modport master (output CEA, AA, CEB, AB, DB, BWB, input init_busy, QA, QA_valid);
    modport slave  (input CEA, AA, CEB, AB, DB, BWB, output init_busy, QA, QA_valid);
endinterface

// File: rtl/dp_ram_bypass_pipe.sv
// dp_ram_bypass_pipe: 1R/1W RAM with write-first bit-masked bypass, 1/2-cycle read latency and init sweep
module dp_ram_bypass_pipe #(
    parameter int                        ADDR_WIDTH    = 6,
    parameter int                        DATA_WIDTH    = 32,
    parameter int                        READ_LATENCY  = 1,
    parameter int                        INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE    = '0
) (
    input logic                  CLK,
    input logic                  rst_n,
    dp_ram_bypass_pipe_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] ST_RST  = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dp_ram_bypass_pipe: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] old_q, old_d;
    logic [DATA_WIDTH-1:0] msk_q, msk_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] qa2_q, qa2_d;
    logic                  run, rd, wr, mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd, merge;

    // next-state: init sweep sequencing, read capture (old word + collision mask) and optional second stage
    always_comb begin
        run     = state_q == ST_RUN;
        rd      = run & bus.CEA;
        wr      = run & bus.CEB;
        merge   = (old_q & ~msk_q) | (dat_q & msk_q);
        state_d = (!run && cnt_q == ADDR_WIDTH'(DEPTH - 1)) ? ST_RUN : state_q;
        cnt_d   = run ? cnt_q : cnt_q + ADDR_WIDTH'(1);
        rv_d    = rd;
        old_d   = rd ? mem[bus.AA] : old_q;
        msk_d   = rd ? ((wr && bus.AB == bus.AA) ? bus.BWB : '0) : msk_q;
        dat_d   = rd ? bus.DB : dat_q;
        v2_d    = rv_q;
        qa2_d   = rv_q ? merge : qa2_q;
        mem_we  = rst_n & (!run | wr);
        mem_wa  = run ? bus.AB : cnt_q;
        mem_wd  = run ? ((mem[bus.AB] & ~bus.BWB) | (bus.DB & bus.BWB)) : INIT_VALUE;
    end

    // control and read pipeline registers
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            old_q   <= '0;
            msk_q   <= '0;
            dat_q   <= '0;
            v2_q    <= 1'b0;
            qa2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            old_q   <= old_d;
            msk_q   <= msk_d;
            dat_q   <= dat_d;
            v2_q    <= v2_d;
            qa2_q   <= qa2_d;
        end
    end

    // storage array, intentionally not reset
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.init_busy = !run;
    assign bus.QA        = (READ_LATENCY == 2) ? qa2_q : merge;
    assign bus.QA_valid  = (READ_LATENCY == 2) ? v2_q : rv_q;
endmodule

// File: tb/tb_dp_ram_bypass_pipe.sv
// tb_dp_ram_bypass_pipe: scoreboard bench for latency-1/2 init-on-reset RAMs plus a no-init instance
module tb_dp_ram_bypass_pipe;
    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic rst_c = 1'b0;
    always #5 CLK = ~CLK;

    logic        cea = 0, ceb = 0;
    logic [5:0]  aa = 0, ab = 0;
    logic [31:0] db = 0, bwb = 0;
    logic        cea_c = 0, ceb_c = 0;
    logic [5:0]  aa_c = 0, ab_c = 0;
    logic [31:0] db_c = 0, bwb_c = 0;

    dp_ram_bypass_pipe_if #(6, 32) ia ();
    dp_ram_bypass_pipe_if #(6, 32) ib ();
    dp_ram_bypass_pipe_if #(6, 32) ic ();

    assign ia.CEA = cea; assign ia.AA = aa; assign ia.CEB = ceb; assign ia.AB = ab; assign ia.DB = db; assign ia.BWB = bwb;
    assign ib.CEA = cea; assign ib.AA = aa; assign ib.CEB = ceb; assign ib.AB = ab; assign ib.DB = db; assign ib.BWB = bwb;
    assign ic.CEA = cea_c; assign ic.AA = aa_c; assign ic.CEB = ceb_c; assign ic.AB = ab_c; assign ic.DB = db_c; assign ic.BWB = bwb_c;

    dp_ram_bypass_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_ON_RESET(1), .INIT_VALUE(32'h0))
        dut_a (.CLK(CLK), .rst_n(rst_n), .bus(ia));
    dp_ram_bypass_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE(32'h0))
        dut_b (.CLK(CLK), .rst_n(rst_n), .bus(ib));
    dp_ram_bypass_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_ON_RESET(0), .INIT_VALUE(32'h0))
        dut_c (.CLK(CLK), .rst_n(rst_c), .bus(ic));

    int checks = 0;
    int failures = 0;
    logic [31:0] mem_m [64];
    logic        model_run = 0;
    logic [31:0] qa_exp [$];
    logic [31:0] qb_exp [$];
    logic [31:0] last_a = 0, last_b = 0;
    logic        done_c = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // one clock of stimulus; the reference model resolves reads write-first
    task automatic cyc(input logic r, input logic [5:0] ra, input logic w, input logic [5:0] wa,
                       input logic [31:0] d, input logic [31:0] m);
        logic [31:0] e;
        cea = r; aa = ra; ceb = w; ab = wa; db = d; bwb = m;
        @(posedge CLK);
        if (model_run) begin
            if (r) begin
                e = mem_m[ra];
                if (w && wa == ra) e = (e & ~m) | (d & m);
                qa_exp.push_back(e);
                qb_exp.push_back(e);
            end
            if (w) mem_m[wa] = (mem_m[wa] & ~m) | (d & m);
        end
        @(negedge CLK);
        cea = 0; ceb = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic hit_reset(input int n);
        model_run = 0;
        rst_n = 0;
        repeat (n) @(negedge CLK);
        rst_n = 1;
    endtask

    // expects init_busy for 64 cycles after release; abort_at>=0 stops early
    task automatic sweep(input int abort_at);
        for (int i = 0; i < 64; i++) begin
            if (i == abort_at) return;
            #1;
            chk("busy_a", 32'(ia.init_busy), 1);
            chk("busy_b", 32'(ib.init_busy), 1);
            @(negedge CLK);
        end
        #1;
        chk("busy_a_done", 32'(ia.init_busy), 0);
        chk("busy_b_done", 32'(ib.init_busy), 0);
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        model_run = 1;
    endtask

    always @(negedge CLK) begin
        if (!rst_n) last_a = 0;
        else if (ia.QA_valid) begin
            if (qa_exp.size() == 0) chk("a_spurious_valid", 32'(ia.QA_valid), 0);
            else begin last_a = qa_exp.pop_front(); chk("a_data", ia.QA, last_a); end
        end else chk("a_hold", ia.QA, last_a);
    end

    always @(negedge CLK) begin
        if (!rst_n) last_b = 0;
        else if (ib.QA_valid) begin
            if (qb_exp.size() == 0) chk("b_spurious_valid", 32'(ib.QA_valid), 0);
            else begin last_b = qb_exp.pop_front(); chk("b_data", ib.QA, last_b); end
        end else chk("b_hold", ib.QA, last_b);
    end

    // no-init instance: usable at the first edge after reset
    initial begin
        repeat (2) @(negedge CLK);
        chk("c_rst_busy", 32'(ic.init_busy), 0);
        chk("c_rst_valid", 32'(ic.QA_valid), 0);
        chk("c_rst_qa", ic.QA, 0);
        ceb_c = 1; ab_c = 0; db_c = 32'h1; bwb_c = 32'hFFFF_FFFF;
        rst_c = 1;
        #1;
        chk("c_busy", 32'(ic.init_busy), 0);
        @(negedge CLK);
        ceb_c = 0; cea_c = 1; aa_c = 0;
        @(negedge CLK);
        cea_c = 0;
        chk("c_valid", 32'(ic.QA_valid), 1);
        chk("c_qa", ic.QA, 32'h1);
        @(negedge CLK);
        chk("c_valid_drop", 32'(ic.QA_valid), 0);
        chk("c_qa_hold", ic.QA, 32'h1);
        done_c = 1;
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("a_rst_qa", ia.QA, 0);
        chk("a_rst_valid", 32'(ia.QA_valid), 0);
        chk("a_rst_busy", 32'(ia.init_busy), 1);
        chk("b_rst_qa", ib.QA, 0);
        chk("b_rst_busy", 32'(ib.init_busy), 1);
        rst_n = 1;
        sweep(-1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 31, 0, 0, 0, 0);
        cyc(1, 63, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 40, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        idle(2);
        hit_reset(2);
        sweep(20);
        hit_reset(2);
        cea = 1; aa = 3; ceb = 1; ab = 7; db = 32'hCAFE_F00D; bwb = 32'hFFFF_FFFF;
        sweep(-1);
        cea = 0; ceb = 0;
        cyc(1, 40, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 5, 32'h1234_5678, 32'h0000_FFFF);
        cyc(1, 5, 0, 0, 0, 0);
        idle(2);
        chk("masked_a", ia.QA, 32'hFFFF_5678);
        chk("masked_b", ib.QA, 32'hFFFF_5678);
        cyc(0, 0, 1, 9, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        cyc(1, 9, 1, 9, 32'h5555_5555, 32'hFF00_FF00);
        idle(2);
        chk("coll_a", ia.QA, 32'h55AA_55AA);
        chk("coll_b", ib.QA, 32'h55AA_55AA);
        chk("coll_a_idle_valid", 32'(ia.QA_valid), 0);
        cyc(0, 0, 1, 1, 32'h11, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 2, 32'h22, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 3, 32'h33, 32'hFFFF_FFFF);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 2, 1, 1, 32'h99, 32'hFFFF_FFFF);
        cyc(1, 3, 0, 0, 0, 0);
        idle(2);
        chk("stream_b_last", ib.QA, 32'h33);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] m;
            case ($urandom_range(0, 2))
                0: m = 32'hFFFF_FFFF;
                1: m = $urandom;
                default: m = 32'h0;
            endcase
            cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 7)), $urandom, m);
        end
        idle(4);
        for (int i = 0; i < 200 && !done_c; i++) @(negedge CLK);
        chk("c_done", 32'(done_c), 1);
        chk("a_pending", qa_exp.size(), 0);
        chk("b_pending", qb_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dp_ram_bypass_pipe.md
Name: dp_ram_bypass_pipe

Overview:
Parametrised single-clock 1R/1W RAM with storage held inside the block. It is the successor of the team's ASIC dual-port wrapper. Beyond per-bit write-mask collision bypass, it adds:
- selectable read latency (1 or 2)
- a read-valid strobe
- output hold between reads
- a post-reset initialisation sweep
It sits behind cache/tag/queue controllers that need deterministic contents after reset and write-first semantics.

Parameters:
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 32, word width in bits
READ_LATENCY, 1, cycles from accepted read to QA/QA_valid; legal values 1 or 2, others are an elaboration error
INIT_ON_RESET, 1, 1: sweep all entries to INIT_VALUE after reset; 0: no sweep, contents undefined
INIT_VALUE, 0, DATA_WIDTH-bit word written by the init sweep

Ports:
CLK  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
init_busy  out  1  1 while init sweep runs; CEA/CEB ignored while 1
CEA  in  1  read enable (1: read)
AA  in  ADDR_WIDTH  read address
QA  out  DATA_WIDTH  read data, held until next read completes
QA_valid  out  1  one-cycle pulse when QA carries new read data
CEB  in  1  write enable (1: write)
AB  in  ADDR_WIDTH  write address
DB  in  DATA_WIDTH  write data
BWB  in  DATA_WIDTH  bit write enable (1: bit written)

Behaviour:
- Reset (rst_n=0, async):
  - QA=0, QA_valid=0, init counter=0, all pipeline/collision registers cleared.
  - init_busy=1 if INIT_ON_RESET=1, else 0.
  - Array contents are not reset.
- Init FSM states: INIT, RUN. Reset enters INIT if INIT_ON_RESET=1, else RUN.
  - INIT: one write per cycle, entry[cnt] <= INIT_VALUE, cnt from 0 to DEPTH-1.
  - After writing DEPTH-1, next state is RUN; init_busy drops on the same edge.
  - Sweep lasts exactly DEPTH cycles after rst_n release.
  - In INIT, CEA and CEB are ignored: no array write, no QA_valid.
  - Reset asserted mid-sweep restarts the sweep at entry 0.
- Write (RUN, CEB=1 at edge T): entry[AB] <= (entry[AB] & ~BWB) | (DB & BWB). BWB=0 leaves the entry unchanged.
- Read (RUN, CEA=1 at edge T): data is the entry value as of edge T, including any write at the same edge T (write-first).
  - READ_LATENCY=1: QA updates and QA_valid=1 in cycle T+1.
  - READ_LATENCY=2: QA updates and QA_valid=1 in cycle T+2; the extra stage is a pure register. A write at T+1 to the same address does not alter data in flight.
- Collision (CEA=CEB=1, AA==AB, same edge):
  - QA = (old & ~BWB) | (DB & BWB); bits not written return old contents.
  - Capture the merge mask/data in a register; bypass applies only to that read's result.
- QA_valid is high only in the cycle new data appears. When not valid, QA holds its last value; it does not return to 0.
- Back-to-back reads at every edge give QA_valid continuously high and fully pipelined, one result per cycle at either latency.
- Different-address read and write in the same cycle are independent.

Test Plan:
- Reset, DEPTH=64, INIT_ON_RESET=1: init_busy high for exactly 64 cycles. Then read entries 0, 31, 63 -> QA=0x00000000 with QA_valid 1 (L=1) or 2 (L=2) cycles after CEA.
- Reset mid-sweep (rst_n low at cycle 20 for 2 cycles, then released): init_busy stays high 64 cycles after release. Entry 40 preset to 0xDEADBEEF, read after the sweep -> 0x00000000. A write issued during init_busy is discarded.
- Masked write: write 0xFFFFFFFF to addr 5, then DB=0x12345678 with BWB=0x0000FFFF -> read addr 5 returns 0xFFFF5678.
- Same-cycle collision: entry 9 = 0xAAAAAAAA; CEA=CEB=1, AA=AB=9, DB=0x55555555, BWB=0xFF00FF00 -> QA=0x55AA55AA. A following idle cycle keeps QA=0x55AA55AA with QA_valid=0.
- READ_LATENCY=2 streaming: reads at addr 1, 2, 3 on consecutive edges (preloaded 0x11, 0x22, 0x33) -> QA sequence 0x11, 0x22, 0x33 on T+2..T+4, QA_valid high for 3 cycles. A write of 0x99 to addr 1 at T+1 does not change the first result.
- INIT_ON_RESET=0: init_busy=0 immediately after reset. A write at the first edge to addr 0 (0x1) followed by a read returns 0x00000001.
